// File: rtl/key_search_pkg.sv
// -----------------------------------------------------------------------------
// key_search_pkg
// Shared definitions for the multi-core RC4 key search coordinator.
//   - coord_state_t : coordinator FSM states
//   - KEY_W_DEF     : default secret key width
//   - CNT_W_DEF     : default search cycle counter width
//   - MAX_CORES     : widest core vector the lowest-set-bit helper handles
//   - lowest_set()  : index of the lowest set bit of a vector (0 if none set)
// -----------------------------------------------------------------------------
package key_search_pkg;

    localparam int KEY_W_DEF = 24;
    localparam int CNT_W_DEF = 32;
    localparam int MAX_CORES = 256;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_SEARCH    = 3'd2,
        ST_FOUND     = 3'd3,
        ST_EXHAUSTED = 3'd4,
        ST_ABORTED   = 3'd5
    } coord_state_t;

    // Scans from the top down so the last hit written is the lowest index.
    function automatic int lowest_set(input logic [MAX_CORES-1:0] v);
        int idx;
        idx = 0;
        for (int i = MAX_CORES - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_search_coordinator_lowest_set_index.sv
// -----------------------------------------------------------------------------
// lowest_set_index
// Parametrised priority encoder: reports the index of the lowest set bit of
// the input vector, plus a flag telling whether any bit is set at all.
// Ports:
//   i_vec   [W-1:0]      input vector (W must not exceed MAX_CORES)
//   o_idx   [IDX_W-1:0]  index of the lowest set bit (0 when none set)
//   o_valid              at least one bit of i_vec is set
// -----------------------------------------------------------------------------
module lowest_set_index
    import key_search_pkg::*;
#(
    parameter int W     = 4,
    parameter int IDX_W = 2
) (
    input  logic [W-1:0]     i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic [MAX_CORES-1:0] w_ext;

    always_comb begin
        w_ext          = '0;
        w_ext[W-1:0]   = i_vec;
        o_idx          = IDX_W'(lowest_set(w_ext));
        o_valid        = |i_vec;
    end

endmodule

// File: rtl/key_search_coordinator.sv
// -----------------------------------------------------------------------------
// key_search_coordinator
// Control block for a multi-core RC4 key search. Hands each core its starting
// key, launches all cores together, latches the first core to find the key,
// detects when every core has exhausted its slice, supports abort and counts
// search cycles.
// Ports:
//   inclk          system clock, rising edge
//   reset_n        asynchronous active-low reset
//   start          request a new search (accepted in IDLE or a terminal state)
//   abort          stop the current search
//   core_finish    per-core key found flag
//   core_fail      per-core slice exhausted flag
//   core_key       per-core current key, core i at [i*KEY_W +: KEY_W]
//   core_start     one-cycle launch pulse to every core
//   core_key_init  starting key per core (core i gets the constant i)
//   stop_all       halt every core (drives flag_other_core_finish)
//   busy           high while launching or searching
//   found          a key has been found
//   exhausted      all cores failed without a find
//   winner_idx     index of the winning core
//   found_key      key reported by the winning core
//   cycle_count    SEARCH cycles spent in the current or last search
// -----------------------------------------------------------------------------
module key_search_coordinator
    import key_search_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int KEY_W     = KEY_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int IDX_W     = $clog2(NUM_CORES > 1 ? NUM_CORES : 2)
) (
    input  logic                       inclk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [NUM_CORES-1:0]       core_finish,
    input  logic [NUM_CORES-1:0]       core_fail,
    input  logic [NUM_CORES*KEY_W-1:0] core_key,
    output logic [NUM_CORES-1:0]       core_start,
    output logic [NUM_CORES*KEY_W-1:0] core_key_init,
    output logic                       stop_all,
    output logic                       busy,
    output logic                       found,
    output logic                       exhausted,
    output logic [IDX_W-1:0]           winner_idx,
    output logic [KEY_W-1:0]           found_key,
    output logic [CNT_W-1:0]           cycle_count
);

    coord_state_t           r_state;
    logic                   r_found;
    logic                   r_exhausted;
    logic                   r_stop_all;
    logic [IDX_W-1:0]       r_winner_idx;
    logic [KEY_W-1:0]       r_found_key;
    logic [CNT_W-1:0]       r_cycle_count;
    logic [NUM_CORES-1:0]   r_fail_sticky;

    logic [IDX_W-1:0]       w_win_idx;
    logic                   w_any_finish;
    logic [KEY_W-1:0]       w_win_key;
    logic                   w_active;
    logic                   w_start_ok;
    logic                   w_fail_all;
    logic [CNT_W-1:0]       w_cnt_next;

    // Core i searches keys i, i+N, i+2N, ... so its seed is simply i.
    genvar g;
    generate
        for (g = 0; g < NUM_CORES; g++) begin : g_key_init
            assign core_key_init[g*KEY_W +: KEY_W] = KEY_W'(g);
        end
    endgenerate

    lowest_set_index #(
        .W     (NUM_CORES),
        .IDX_W (IDX_W)
    ) u_winner (
        .i_vec   (core_finish),
        .o_idx   (w_win_idx),
        .o_valid (w_any_finish)
    );

    // Key of the winning core, taken in the same cycle its finish flag is seen.
    always_comb begin
        w_win_key = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (w_win_idx == IDX_W'(i)) begin
                w_win_key = core_key[i*KEY_W +: KEY_W];
            end
        end
    end

    assign w_active   = (r_state == ST_LAUNCH) || (r_state == ST_SEARCH);
    assign w_start_ok = start && !abort && !w_active;
    // Current-cycle fails count too, so a last pulse exhausts without delay.
    assign w_fail_all = &(r_fail_sticky | core_fail);
    assign w_cnt_next = (&r_cycle_count) ? r_cycle_count : (r_cycle_count + CNT_W'(1));

    always_ff @(posedge inclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_found       <= 1'b0;
            r_exhausted   <= 1'b0;
            r_stop_all    <= 1'b0;
            r_winner_idx  <= '0;
            r_found_key   <= '0;
            r_cycle_count <= '0;
            r_fail_sticky <= '0;
        end else begin
            case (r_state)
                ST_LAUNCH: begin
                    // Finish/fail flags are ignored here; they may be left
                    // over from the previous search.
                    if (abort) begin
                        r_state    <= ST_ABORTED;
                        r_stop_all <= 1'b1;
                    end else begin
                        r_state    <= ST_SEARCH;
                    end
                end

                ST_SEARCH: begin
                    r_cycle_count <= w_cnt_next;
                    r_fail_sticky <= r_fail_sticky | core_fail;
                    if (w_any_finish) begin
                        r_state      <= ST_FOUND;
                        r_found      <= 1'b1;
                        r_stop_all   <= 1'b1;
                        r_winner_idx <= w_win_idx;
                        r_found_key  <= w_win_key;
                    end else if (abort) begin
                        r_state      <= ST_ABORTED;
                        r_stop_all   <= 1'b1;
                    end else if (w_fail_all) begin
                        r_state      <= ST_EXHAUSTED;
                        r_exhausted  <= 1'b1;
                        r_stop_all   <= 1'b1;
                    end
                end

                default: begin
                    // IDLE and the terminal states hold their results until
                    // a new search is accepted; results clear on acceptance
                    // so they read zero throughout LAUNCH.
                    if (w_start_ok) begin
                        r_state       <= ST_LAUNCH;
                        r_found       <= 1'b0;
                        r_exhausted   <= 1'b0;
                        r_stop_all    <= 1'b0;
                        r_winner_idx  <= '0;
                        r_found_key   <= '0;
                        r_cycle_count <= '0;
                        r_fail_sticky <= '0;
                    end
                end
            endcase
        end
    end

    assign core_start  = {NUM_CORES{r_state == ST_LAUNCH}};
    assign busy        = w_active;
    assign stop_all    = r_stop_all;
    assign found       = r_found;
    assign exhausted   = r_exhausted;
    assign winner_idx  = r_winner_idx;
    assign found_key   = r_found_key;
    assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_key_search_coordinator.sv
module tb_key_search_coordinator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Four-core instance
    logic        rst_n, start, abort;
    logic [3:0]  fin, fail;
    logic [95:0] key;
    logic [3:0]  core_start;
    logic [95:0] key_init;
    logic        stop_all, busy, found, exhausted;
    logic [1:0]  winner_idx;
    logic [23:0] found_key;
    logic [31:0] cycle_count;

    // Single-core instance with a narrow counter
    logic        start2, abort2;
    logic [0:0]  fin2, fail2, core_start2, winner_idx2;
    logic [23:0] key2, key_init2, found_key2;
    logic        stop_all2, busy2, found2, exhausted2;
    logic [3:0]  cycle_count2;

    key_search_coordinator #(.NUM_CORES(4), .KEY_W(24), .CNT_W(32)) dut (
        .inclk(clk), .reset_n(rst_n), .start(start), .abort(abort),
        .core_finish(fin), .core_fail(fail), .core_key(key),
        .core_start(core_start), .core_key_init(key_init), .stop_all(stop_all),
        .busy(busy), .found(found), .exhausted(exhausted), .winner_idx(winner_idx),
        .found_key(found_key), .cycle_count(cycle_count)
    );

    key_search_coordinator #(.NUM_CORES(1), .KEY_W(24), .CNT_W(4)) dut1 (
        .inclk(clk), .reset_n(rst_n), .start(start2), .abort(abort2),
        .core_finish(fin2), .core_fail(fail2), .core_key(key2),
        .core_start(core_start2), .core_key_init(key_init2), .stop_all(stop_all2),
        .busy(busy2), .found(found2), .exhausted(exhausted2), .winner_idx(winner_idx2),
        .found_key(found_key2), .cycle_count(cycle_count2)
    );

    int n_err = 0;
    int n_chk = 0;

    // Per-SEARCH-cycle scenario: index k is the (k+1)th SEARCH cycle
    logic [3:0]  sc_fin  [64];
    logic [3:0]  sc_fail [64];
    logic        sc_ab   [64];
    logic [95:0] sc_key  [64];

    // Outcome kinds: 0 found, 1 aborted, 2 exhausted
    typedef struct {
        int          idle;
        logic [3:0]  fin;
        logic [3:0]  fl;
        logic        ab;
        logic [95:0] keys;
        logic [3:0]  lfin;
        logic        sis;
        int          ek;
        int          ec;
        int          ei;
        logic [23:0] ekey;
    } row_t;

    row_t tbl [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sc();
        for (int i = 0; i < 64; i++) begin
            sc_fin[i] = '0; sc_fail[i] = '0; sc_ab[i] = 1'b0; sc_key[i] = '0;
        end
    endtask

    // Reference: walk the scenario cycle by cycle using the search rules.
    function automatic void model(input int len, output int ek, output int ec,
                                  output int ei, output logic [23:0] ekey);
        logic [3:0] seen;
        seen = '0; ek = -1; ec = len; ei = 0; ekey = '0;
        for (int k = 0; k < len; k++) begin
            seen = seen | sc_fail[k];
            if (sc_fin[k] != 4'h0) begin
                ek = 0; ec = k + 1;
                for (int i = 3; i >= 0; i--) if (sc_fin[k][i]) ei = i;
                ekey = sc_key[k][ei*24 +: 24];
                return;
            end else if (sc_ab[k]) begin
                ek = 1; ec = k + 1;
                return;
            end else if (seen == 4'hF) begin
                ek = 2; ec = k + 1;
                return;
            end
        end
    endfunction

    task automatic run(input logic [3:0] lfin, input logic sis, input int ek,
                       input int ec, input int ei, input logic [23:0] ekey);
        start = 1'b1; abort = 1'b0; fin = '0; fail = '0;
        step();
        chk("launch_core_start", core_start, 4'hF);
        chk("launch_busy", busy, 1);
        chk("launch_found", found, 0);
        chk("launch_exh", exhausted, 0);
        chk("launch_stop", stop_all, 0);
        chk("launch_idx", winner_idx, 0);
        chk("launch_key", found_key, 0);
        chk("launch_cnt", cycle_count, 0);
        start = 1'b0; fin = lfin; fail = lfin;
        step();
        chk("search0_core_start", core_start, 4'h0);
        chk("search0_busy", busy, 1);
        chk("search0_cnt", cycle_count, 0);
        for (int k = 0; k < ec; k++) begin
            fin = sc_fin[k]; fail = sc_fail[k]; abort = sc_ab[k]; key = sc_key[k]; start = sis;
            step();
            if (k < ec - 1) begin
                chk("search_busy", busy, 1);
                chk("search_stop", stop_all, 0);
                chk("search_found", found, 0);
                chk("search_cnt", cycle_count, 64'(k + 1));
            end
        end
        start = 1'b0; abort = 1'b0; fin = '0; fail = '0;
        chk("end_busy", busy, 0);
        chk("end_stop", stop_all, 1);
        chk("end_found", found, (ek == 0) ? 1 : 0);
        chk("end_exh", exhausted, (ek == 2) ? 1 : 0);
        chk("end_idx", winner_idx, 64'(ei));
        chk("end_key", found_key, ekey);
        chk("end_cnt", cycle_count, 64'(ec));
        step();
        chk("hold_found", found, (ek == 0) ? 1 : 0);
        chk("hold_stop", stop_all, 1);
        chk("hold_key", found_key, ekey);
        chk("hold_cnt", cycle_count, 64'(ec));
        chk("hold_core_start", core_start, 4'h0);
    endtask

    initial begin
        int ek, ec, ei, len;
        logic [23:0] ekey;

        tbl[0] = '{9, 4'b0100, 4'b0000, 1'b0, {24'h333333, 24'h00A3B6, 24'h222222, 24'h111111}, 4'h0, 1'b0, 0, 10, 2, 24'h00A3B6};
        tbl[1] = '{2, 4'b1010, 4'b0000, 1'b0, {24'hCCCCCC, 24'hBBBBBB, 24'h5A5A5A, 24'hAAAAAA}, 4'h0, 1'b0, 0, 3, 1, 24'h5A5A5A};
        tbl[2] = '{4, 4'b0000, 4'b0000, 1'b1, {24'h010101, 24'h020202, 24'h030303, 24'h040404}, 4'h0, 1'b0, 1, 5, 0, 24'h000000};
        tbl[3] = '{0, 4'b0100, 4'b0100, 1'b0, {24'h444444, 24'h0BEEF2, 24'h666666, 24'h777777}, 4'h0, 1'b0, 0, 1, 2, 24'h0BEEF2};
        tbl[4] = '{0, 4'b0000, 4'b1111, 1'b0, {24'h123456, 24'h234567, 24'h345678, 24'h456789}, 4'h0, 1'b0, 2, 1, 0, 24'h000000};
        tbl[5] = '{3, 4'b0001, 4'b0000, 1'b1, {24'h999999, 24'h888888, 24'h777777, 24'h0C0DE0}, 4'h0, 1'b0, 0, 4, 0, 24'h0C0DE0};
        tbl[6] = '{6, 4'b0000, 4'b0000, 1'b1, {24'h0F0F0F, 24'hF0F0F0, 24'h00FF00, 24'hFF00FF}, 4'b0001, 1'b1, 1, 7, 0, 24'h000000};
        tbl[7] = '{0, 4'b1000, 4'b0111, 1'b0, {24'hABC123, 24'h111222, 24'h333444, 24'h555666}, 4'h0, 1'b0, 0, 1, 3, 24'hABC123};

        rst_n = 1'b0; start = 0; abort = 0; fin = 0; fail = 0; key = 0;
        start2 = 0; abort2 = 0; fin2 = 0; fail2 = 0; key2 = 24'h5EED01;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_stop", stop_all, 0);
        chk("rst_found", found, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_cnt", cycle_count, 0);
        for (int i = 0; i < 4; i++) chk("key_init", key_init[i*24 +: 24], 64'(i));
        rst_n = 1'b1;
        step();
        chk("idle_busy", busy, 0);

        // Directed table
        for (int r = 0; r < 8; r++) begin
            clear_sc();
            for (int k = 0; k <= tbl[r].idle; k++) sc_key[k] = tbl[r].keys;
            sc_fin[tbl[r].idle]  = tbl[r].fin;
            sc_fail[tbl[r].idle] = tbl[r].fl;
            sc_ab[tbl[r].idle]   = tbl[r].ab;
            run(tbl[r].lfin, tbl[r].sis, tbl[r].ek, tbl[r].ec, tbl[r].ei, tbl[r].ekey);
        end

        // Fail pulses from cores 0, 3, 1, 2 in turn
        clear_sc();
        sc_fail[0] = 4'b0001; sc_fail[2] = 4'b1000; sc_fail[3] = 4'b0010; sc_fail[4] = 4'b0100;
        run(4'h0, 1'b0, 2, 5, 0, 24'h000000);

        // Reset asserted mid-search clears outputs without waiting for a clock
        start = 1'b1; step(); start = 1'b0; step(); step(); step(); step();
        chk("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt", cycle_count, 0);
        chk("mid_rst_core_start", core_start, 0);
        chk("mid_rst_stop", stop_all, 0);
        #3 rst_n = 1'b1;
        step();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_found", found, 0);

        // Randomized searches against the model
        for (int r = 0; r < 40; r++) begin
            clear_sc();
            len = int'($urandom_range(1, 30));
            for (int k = 0; k < len; k++) begin
                sc_key[k]  = {$urandom, $urandom, $urandom};
                sc_fin[k]  = ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'h0;
                sc_fail[k] = 4'($urandom & $urandom & $urandom);
                sc_ab[k]   = ($urandom_range(0, 19) == 0);
            end
            sc_ab[len-1] = 1'b1;
            model(len, ek, ec, ei, ekey);
            run(4'($urandom), 1'($urandom), ek, ec, ei, ekey);
        end

        // Single core, 4-bit counter: saturation and winner index 0
        start2 = 1'b1; step();
        chk("one_core_start", core_start2, 1);
        start2 = 1'b0; step();
        for (int k = 0; k < 20; k++) step();
        chk("one_cnt_sat", cycle_count2, 4'hF);
        chk("one_busy", busy2, 1);
        fin2 = 1'b1; step(); fin2 = 1'b0;
        chk("one_found", found2, 1);
        chk("one_idx", winner_idx2, 0);
        chk("one_key", found_key2, 24'h5EED01);
        chk("one_cnt_final", cycle_count2, 4'hF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
